// File: rtl/tower_placer_control.sv
// ============================================================================
// tower_placer_control: key-driven control FSM for the tower-placer datapath.
// Optional build macro: TOWER_PLACER_CMD_QUEUE_EN (one-entry pending command).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tower_placer_control #(
    parameter int SYNC_STAGES  = 2,
    parameter int DONE_TIMEOUT = 4096,
    parameter int TO_W         = 13
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_right_n,
    input  logic       key_down_n,
    input  logic       key_place_n,
    input  logic       valid,
    input  logic       square_done,
    input  logic       erase_square_done,
    input  logic       tower_done,
    output logic       top_left,
    output logic       draw_square,
    output logic       move_right,
    output logic       move_down,
    output logic       move_right_wait,
    output logic       move_down_wait,
    output logic       erase_square_right,
    output logic       erase_square_down,
    output logic       erase_square_tower,
    output logic       draw_tower,
    output logic       busy,
    output logic       fault,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_TOP_LEFT    = 4'd0,
        S_DRAW_SQ     = 4'd1,
        S_IDLE        = 4'd2,
        S_ERASE_R     = 4'd3,
        S_MOVE_R      = 4'd4,
        S_MOVE_R_WAIT = 4'd5,
        S_ERASE_D     = 4'd6,
        S_MOVE_D      = 4'd7,
        S_MOVE_D_WAIT = 4'd8,
        S_ERASE_T     = 4'd9,
        S_DRAW_T      = 4'd10
    } state_t;

    localparam logic [TO_W-1:0] c_timeout = TO_W'(DONE_TIMEOUT);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [2:0]      keys_n;
    logic [2:0]      press;
    logic [1:0]      cmd_fresh;
    logic [1:0]      cmd_sel;
    logic            waiting;

    assign keys_n = {key_place_n, key_down_n, key_right_n};

    // Synchroniser, then a registered falling-edge detector per key.
    for (genvar g = 0; g < 3; g++) begin : g_key
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   prev_q, prev_d;
        logic                   pulse_q, pulse_d;

        always_comb begin
            sync_d  = {sync_q[SYNC_STAGES-2:0], keys_n[g]};
            prev_d  = sync_q[SYNC_STAGES-1];
            pulse_d = prev_q & ~sync_q[SYNC_STAGES-1];
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                sync_q  <= '1;
                prev_q  <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                prev_q  <= prev_d;
                pulse_q <= pulse_d;
            end
        end

        assign press[g] = pulse_q;
    end

    // Command codes double as priorities: place(3) > right(2) > down(1).
    assign cmd_fresh = press[2] ? 2'd3 :
                       press[0] ? 2'd2 :
                       press[1] ? 2'd1 : 2'd0;

    assign waiting = state_q inside {S_DRAW_SQ, S_ERASE_R, S_ERASE_D, S_ERASE_T,
                                     S_MOVE_R, S_MOVE_D, S_DRAW_T};
    assign fault   = waiting && (cnt_q == c_timeout);

`ifdef TOWER_PLACER_CMD_QUEUE_EN
    logic [1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (fault || state_q == S_IDLE) begin
            pend_d = 2'd0;
        end else if (cmd_fresh > pend_q) begin
            pend_d = cmd_fresh;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 2'd0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign cmd_sel = (pend_q > cmd_fresh) ? pend_q : cmd_fresh;
`else
    assign cmd_sel = cmd_fresh;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TOP_LEFT:    state_d = S_DRAW_SQ;
            S_DRAW_SQ:     if (square_done) state_d = S_IDLE;
            S_IDLE: begin
                case (cmd_sel)
                    2'd3:    state_d = S_ERASE_T;
                    2'd2:    state_d = S_ERASE_R;
                    2'd1:    state_d = S_ERASE_D;
                    default: state_d = S_IDLE;
                endcase
            end
            S_ERASE_R:     if (erase_square_done) state_d = S_MOVE_R;
            S_MOVE_R:      if (valid) state_d = S_MOVE_R_WAIT;
            S_MOVE_R_WAIT: state_d = S_DRAW_SQ;
            S_ERASE_D:     if (erase_square_done) state_d = S_MOVE_D;
            S_MOVE_D:      if (valid) state_d = S_MOVE_D_WAIT;
            S_MOVE_D_WAIT: state_d = S_DRAW_SQ;
            S_ERASE_T:     if (erase_square_done) state_d = S_DRAW_T;
            S_DRAW_T:      if (tower_done) state_d = S_DRAW_SQ;
            default:       state_d = S_TOP_LEFT;
        endcase
        if (fault) begin
            state_d = S_TOP_LEFT;
        end

        cnt_d = '0;
        if (waiting && state_d == state_q) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_TOP_LEFT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        top_left           = 1'b0;
        draw_square        = 1'b0;
        move_right         = 1'b0;
        move_down          = 1'b0;
        move_right_wait    = 1'b0;
        move_down_wait     = 1'b0;
        erase_square_right = 1'b0;
        erase_square_down  = 1'b0;
        erase_square_tower = 1'b0;
        draw_tower         = 1'b0;
        case (state_q)
            S_TOP_LEFT:    top_left           = 1'b1;
            S_DRAW_SQ:     draw_square        = 1'b1;
            S_ERASE_R:     erase_square_right = 1'b1;
            S_MOVE_R:      move_right         = 1'b1;
            S_MOVE_R_WAIT: move_right_wait    = 1'b1;
            S_ERASE_D:     erase_square_down  = 1'b1;
            S_MOVE_D:      move_down          = 1'b1;
            S_MOVE_D_WAIT: move_down_wait     = 1'b1;
            S_ERASE_T:     erase_square_tower = 1'b1;
            S_DRAW_T:      draw_tower         = 1'b1;
            default:       ;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_tower_placer_control.sv
// ============================================================================
// tb_tower_placer_control: directed table, hand sequences and random stimulus
// against a cycle-level reference model of tower_placer_control.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tower_placer_control;

    localparam int SS         = 2;
    localparam int TB_TIMEOUT = 24;
    localparam int TB_TO_W    = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_right_n = 1'b1, key_down_n = 1'b1, key_place_n = 1'b1;
    logic       valid = 1'b0, square_done = 1'b0, erase_square_done = 1'b0, tower_done = 1'b0;
    logic       top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
    logic       erase_square_right, erase_square_down, erase_square_tower, draw_tower;
    logic       busy, fault;
    logic [3:0] state_dbg;

    always #5 clk = ~clk;

    tower_placer_control #(
        .SYNC_STAGES (SS),
        .DONE_TIMEOUT(TB_TIMEOUT),
        .TO_W        (TB_TO_W)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .key_right_n       (key_right_n),
        .key_down_n        (key_down_n),
        .key_place_n       (key_place_n),
        .valid             (valid),
        .square_done       (square_done),
        .erase_square_done (erase_square_done),
        .tower_done        (tower_done),
        .top_left          (top_left),
        .draw_square       (draw_square),
        .move_right        (move_right),
        .move_down         (move_down),
        .move_right_wait   (move_right_wait),
        .move_down_wait    (move_down_wait),
        .erase_square_right(erase_square_right),
        .erase_square_down (erase_square_down),
        .erase_square_tower(erase_square_tower),
        .draw_tower        (draw_tower),
        .busy              (busy),
        .fault             (fault),
        .state_dbg         (state_dbg)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    int m_state, m_dwell, m_pend;
    bit samp [3][SS+2];   // per key: pin value sampled at the last SS+2 edges, [0] newest

    // Which feedback releases a state: 0 unconditional, 1 valid, 2 square_done,
    // 3 erase_square_done, 4 tower_done, 5 key press (idle).
    function automatic int gate(int s);
        case (s)
            1:       return 2;
            2:       return 5;
            3, 6, 9: return 3;
            4, 7:    return 1;
            10:      return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int succ(int s);
        case (s)
            0: return 1;   1: return 2;   3: return 4;   4: return 5;   5: return 1;
            6: return 7;   7: return 8;   8: return 1;   9: return 10; 10: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit waits(int s);
        return gate(s) >= 1 && gate(s) <= 4;
    endfunction

    function automatic bit fb_of(int g);
        case (g)
            1:       return valid;
            2:       return square_done;
            3:       return erase_square_done;
            4:       return tower_done;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] strobes(int s);
        case (s)
            0:       return 10'b1000000000;
            1:       return 10'b0100000000;
            4:       return 10'b0010000000;
            7:       return 10'b0001000000;
            5:       return 10'b0000100000;
            8:       return 10'b0000010000;
            3:       return 10'b0000001000;
            6:       return 10'b0000000100;
            9:       return 10'b0000000010;
            10:      return 10'b0000000001;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic bit pulse(int k);
        return !samp[k][SS] && samp[k][SS+1];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_dwell = 0;
        m_pend  = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < SS + 2; i++) samp[k][i] = 1'b1;
    endtask

    task automatic model_edge();
        int nxt, cmd, fresh;
        bit to;
        logic [2:0] pins;
        if (!resetn) begin
            model_reset();
            return;
        end
        pins  = {key_place_n, key_down_n, key_right_n};
        fresh = pulse(2) ? 3 : pulse(0) ? 2 : pulse(1) ? 1 : 0;
        cmd   = fresh;
`ifdef TOWER_PLACER_CMD_QUEUE_EN
        if (m_pend > cmd) cmd = m_pend;
`endif
        to = waits(m_state) && m_dwell == TB_TIMEOUT;
        if (to) nxt = 0;
        else if (gate(m_state) == 0) nxt = succ(m_state);
        else if (gate(m_state) == 5) nxt = (cmd == 3) ? 9 : (cmd == 2) ? 3 : (cmd == 1) ? 6 : 2;
        else nxt = fb_of(gate(m_state)) ? succ(m_state) : m_state;
`ifdef TOWER_PLACER_CMD_QUEUE_EN
        if (to || m_state == 2) m_pend = 0;
        else if (fresh > m_pend) m_pend = fresh;
`endif
        m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
        m_state = nxt;
        for (int k = 0; k < 3; k++) begin
            for (int i = SS + 1; i > 0; i--) samp[k][i] = samp[k][i-1];
            samp[k][0] = pins[k];
        end
    endtask

    function automatic logic [15:0] exp_vec();
        return {strobes(m_state), m_state != 2,
                waits(m_state) && m_dwell == TB_TIMEOUT, 4'(m_state)};
    endfunction

    function automatic logic [15:0] act_vec();
        return {top_left, draw_square, move_right, move_down, move_right_wait,
                move_down_wait, erase_square_right, erase_square_down,
                erase_square_tower, draw_tower, busy, fault, state_dbg};
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", act_vec(), exp_vec());
    endtask

    task automatic set_in(logic [2:0] k, logic [3:0] f);
        {key_place_n, key_down_n, key_right_n} = k;
        {valid, square_done, erase_square_done, tower_done} = f;
    endtask

    task automatic go_idle();
        int n = 0;
        set_in(3'b111, 4'b0000);
        while (state_dbg != 4'd2 && n < 60) begin
            valid             = (state_dbg == 4'd4 || state_dbg == 4'd7);
            square_done       = (state_dbg == 4'd1);
            erase_square_done = (state_dbg == 4'd3 || state_dbg == 4'd6 || state_dbg == 4'd9);
            tower_done        = (state_dbg == 4'd10);
            step();
            n++;
        end
        set_in(3'b111, 4'b0000);
        check("go_idle", {12'd0, state_dbg}, 16'd2);
        repeat (4) step();
    endtask

    task automatic to_draw_sq();
        set_in(3'b110, 4'b0000);
        repeat (4) step();
        set_in(3'b111, 4'b0010);
        step();
        set_in(3'b111, 4'b1000);
        step();
        set_in(3'b111, 4'b0000);
        step();
        check("to_draw_sq", {12'd0, state_dbg}, 16'd1);
    endtask

    typedef struct {
        logic [2:0] keys_n;    // {place, down, right}
        logic [3:0] fb;        // {valid, square_done, erase_square_done, tower_done}
        int         cycles;
        logic [3:0] exp_state;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [3:0] exp_pend;
        int prob;

        tbl[0]  = '{3'b111, 4'b0000,  1, 4'd1,  1'b1};
        tbl[1]  = '{3'b111, 4'b0000, 19, 4'd1,  1'b1};
        tbl[2]  = '{3'b111, 4'b0100,  1, 4'd2,  1'b0};
        tbl[3]  = '{3'b111, 4'b0000,  3, 4'd2,  1'b0};
        tbl[4]  = '{3'b110, 4'b0000,  4, 4'd3,  1'b1};
        tbl[5]  = '{3'b110, 4'b0000,  9, 4'd3,  1'b1};
        tbl[6]  = '{3'b110, 4'b0010,  1, 4'd4,  1'b1};
        tbl[7]  = '{3'b110, 4'b1000,  1, 4'd5,  1'b1};
        tbl[8]  = '{3'b110, 4'b0000,  1, 4'd1,  1'b1};
        tbl[9]  = '{3'b110, 4'b0100,  1, 4'd2,  1'b0};
        tbl[10] = '{3'b110, 4'b0000, 34, 4'd2,  1'b0};
        tbl[11] = '{3'b111, 4'b0000,  5, 4'd2,  1'b0};
        tbl[12] = '{3'b001, 4'b0000,  4, 4'd9,  1'b1};
        tbl[13] = '{3'b111, 4'b0010,  1, 4'd10, 1'b1};
        tbl[14] = '{3'b111, 4'b0000,  3, 4'd10, 1'b1};
        tbl[15] = '{3'b111, 4'b0001,  1, 4'd1,  1'b1};
        tbl[16] = '{3'b111, 4'b0100,  1, 4'd2,  1'b0};
        tbl[17] = '{3'b111, 4'b0000,  6, 4'd2,  1'b0};

        model_reset();
        repeat (3) step();
        resetn = 1'b1;
        check("reset_state", act_vec(), {10'b1000000000, 1'b1, 1'b0, 4'd0});

        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].keys_n, tbl[i].fb);
            repeat (tbl[i].cycles) step();
            check($sformatf("tbl%0d", i), {11'd0, busy, state_dbg},
                  {11'd0, tbl[i].exp_busy, tbl[i].exp_state});
        end
        set_in(3'b111, 4'b0000);

        // Down pressed while the square is being drawn.
        to_draw_sq();
        set_in(3'b101, 4'b0000);
        repeat (3) step();
        set_in(3'b111, 4'b0000);
        step();
        set_in(3'b111, 4'b0100);
        step();
        check("busy_press_idle", {12'd0, state_dbg}, 16'd2);
        set_in(3'b111, 4'b0000);
        step();
`ifdef TOWER_PLACER_CMD_QUEUE_EN
        exp_pend = 4'd6;
`else
        exp_pend = 4'd2;
`endif
        check("busy_press_next", {12'd0, state_dbg}, {12'd0, exp_pend});
        repeat (3) step();
        check("busy_press_hold", {12'd0, state_dbg}, {12'd0, exp_pend});
        go_idle();

        // Watchdog with square_done never returned.
        to_draw_sq();
        repeat (TB_TIMEOUT) step();
        check("wd_fault", {11'd0, fault, state_dbg}, {11'd0, 1'b1, 4'd1});
        step();
        check("wd_home", {top_left, 10'd0, fault, state_dbg}, {1'b1, 10'd0, 1'b0, 4'd0});
        step();
        check("wd_redraw", {12'd0, state_dbg}, 16'd1);
        go_idle();

        // Asynchronous reset in the middle of a down move.
        set_in(3'b101, 4'b0000);
        repeat (4) step();
        set_in(3'b111, 4'b0010);
        step();
        set_in(3'b111, 4'b0000);
        check("in_move_d", {12'd0, state_dbg}, 16'd7);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_rst", act_vec(), {10'b1000000000, 1'b1, 1'b0, 4'd0});
        repeat (2) step();
        resetn = 1'b1;
        step();
        check("rst_restart", {12'd0, state_dbg}, 16'd1);
        go_idle();

        // Random keys and feedback at varying feedback densities.
        for (int seg = 0; seg < 15; seg++) begin
            case ($urandom_range(0, 3))
                0:       prob = 0;
                1:       prob = 5;
                2:       prob = 30;
                default: prob = 60;
            endcase
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 15) == 0) key_right_n = ~key_right_n;
                if ($urandom_range(0, 15) == 0) key_down_n  = ~key_down_n;
                if ($urandom_range(0, 15) == 0) key_place_n = ~key_place_n;
                valid             = ($urandom_range(0, 99) < prob);
                square_done       = ($urandom_range(0, 99) < prob);
                erase_square_done = ($urandom_range(0, 99) < prob);
                tower_done        = ($urandom_range(0, 99) < prob);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tower_placer_control.md
Name: tower_placer_control

Overview:
- Control FSM directly upstream of the tower-placer datapath.
- Turns the player's cursor keys into the datapath's one-hot control strobes: top_left, draw_square, move_right, move_down, move_down_wait, move_right_wait, draw_tower, erase_square_right, erase_square_down, erase_square_tower.
- Sequences those strobes against the datapath feedback: valid, square_done, erase_square_done, tower_done.
- Includes key synchronisation, press edge detection and a feedback watchdog.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each key input; legal range 2..4.
- DONE_TIMEOUT, 4096: maximum cycles spent in any state that waits on feedback before fault recovery.
- TO_W, 13: width of the watchdog counter; must satisfy 2^TO_W > DONE_TIMEOUT.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- key_right_n  in  1  move-right key, active-low, asynchronous to clk
- key_down_n  in  1  move-down key, active-low, asynchronous
- key_place_n  in  1  place-tower key, active-low, asynchronous
- valid  in  1  datapath: cursor move accepted
- square_done  in  1  datapath: selection square drawn
- erase_square_done  in  1  datapath: square erased
- tower_done  in  1  datapath: tower sprite drawn
- top_left  out  1  strobe to datapath
- draw_square  out  1  strobe to datapath
- move_right  out  1  strobe to datapath
- move_down  out  1  strobe to datapath
- move_right_wait  out  1  strobe to datapath
- move_down_wait  out  1  strobe to datapath
- erase_square_right  out  1  strobe to datapath
- erase_square_down  out  1  strobe to datapath
- erase_square_tower  out  1  strobe to datapath
- draw_tower  out  1  strobe to datapath
- busy  out  1  high in every state except S_IDLE
- fault  out  1  one-cycle pulse when the watchdog expires
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - Asynchronous, active-low on resetn; every flop clears immediately.
  - State resets to S_TOP_LEFT, so top_left=1 and all other strobes=0.
  - busy=1, fault=0, state_dbg=0, synchroniser flops = 1 (keys released).
- Key path:
  - Each key passes SYNC_STAGES flops, then a falling-edge detector.
  - Result is a one-cycle press pulse, SYNC_STAGES+1 cycles after the pin falls.
  - A held key produces exactly one pulse.
- Outputs: Moore, decoded combinationally from the registered state; exactly one strobe is high in any state except S_IDLE, where none is high.
- States (state_dbg value) and transitions:
  - S_TOP_LEFT (0): asserts top_left; after 1 cycle -> S_DRAW_SQ.
  - S_DRAW_SQ (1): asserts draw_square; on square_done=1 -> S_IDLE.
  - S_IDLE (2): no strobe, busy=0.
    - Press priority when several pulses arrive in the same cycle: place > right > down.
    - place -> S_ERASE_T; right -> S_ERASE_R; down -> S_ERASE_D.
  - S_ERASE_R (3): asserts erase_square_right; on erase_square_done -> S_MOVE_R.
  - S_MOVE_R (4): asserts move_right; on valid=1 -> S_MOVE_R_WAIT.
  - S_MOVE_R_WAIT (5): asserts move_right_wait for exactly 1 cycle (clears datapath valid) -> S_DRAW_SQ.
  - S_ERASE_D (6), S_MOVE_D (7), S_MOVE_D_WAIT (8): same as the right path, using the down strobes.
  - S_ERASE_T (9): asserts erase_square_tower; on erase_square_done -> S_DRAW_T.
  - S_DRAW_T (10): asserts draw_tower; on tower_done=1 -> S_DRAW_SQ.
- Feedback is sampled in the same cycle it is seen; the transition takes effect at the next clk edge.
- Presses outside S_IDLE are discarded (baseline build).
- Watchdog:
  - Counter clears on every state change.
  - Increments in S_DRAW_SQ, S_ERASE_*, S_MOVE_R, S_MOVE_D and S_DRAW_T.
  - On reaching DONE_TIMEOUT: fault pulses for 1 cycle and the FSM moves to S_TOP_LEFT (cursor home, redraw).
- Feedback arriving while the FSM sits in a state that does not wait on it is ignored.
- Reset asserted mid-sequence aborts immediately; the FSM restarts at S_TOP_LEFT on release.
- Unused encodings 11..15 -> S_TOP_LEFT on the next clock.

Optional Feature:
- Macro: TOWER_PLACER_CMD_QUEUE_EN.
- Defined:
  - A one-entry pending-command register captures the highest-priority press seen while busy.
  - A later press overwrites it only if it has higher priority.
  - On entering S_IDLE with the entry valid, the FSM dispatches it on the next cycle as if it were a fresh press, and the entry clears.
  - Reset and watchdog fault clear the entry.
- Undefined: presses while busy are dropped; no extra state.

Test Plan:
- Reset release, datapath returns square_done 20 cycles later -> top_left high for exactly 1 cycle, draw_square for 20 cycles, then S_IDLE with busy=0 and state_dbg=2.
- In S_IDLE, hold key_right_n low for 50 cycles, with erase_square_done after 10 cycles and valid after 1 cycle:
  - sequence is erase_square_right x10, move_right x1, move_right_wait x1, then draw_square;
  - only one move occurs despite the held key.
- key_place_n and key_down_n fall in the same cycle -> erase_square_tower, then draw_tower until tower_done; the down press is dropped (queue macro off).
- Press down while in S_DRAW_SQ:
  - macro off: FSM returns to S_IDLE and stays there;
  - macro on: S_ERASE_D is entered 1 cycle after S_IDLE.
- Never assert square_done, with DONE_TIMEOUT=16 -> fault pulses 16 cycles after entering S_DRAW_SQ, then top_left is asserted on the next cycle.
- Assert resetn low during S_MOVE_D -> all strobes except top_left drop asynchronously, with no clock edge required; state_dbg=0.
